// File: rtl/load_store_unit_pkg.sv
// Shared types and lane helpers for the RV32I load/store unit.
// Build option: LSU_MISALIGN_TRAP_EN turns misaligned halfword/word accesses into errors.
package riscv_lsu_pkg;

  localparam int LSU_XLEN = 32;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    RSP  = 2'd3
  } lsu_state_e;

  // Byte offset actually used; address bits below the access size are dropped.
  function automatic logic [1:0] lane_off(input logic [2:0] f3, input logic [1:0] a);
    case (f3[1:0])
      2'b00:   return a;
      2'b01:   return {a[1], 1'b0};
      default: return 2'b00;
    endcase
  endfunction

  function automatic logic [3:0] lane_mask(input logic [2:0] f3, input logic [1:0] a);
    case (f3[1:0])
      2'b00:   return 4'b0001 << lane_off(f3, a);
      2'b01:   return 4'b0011 << lane_off(f3, a);
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] extend(input logic [31:0] v, input logic [2:0] f3);
    case (f3)
      F3_B:    return {{24{v[7]}}, v[7:0]};
      F3_H:    return {{16{v[15]}}, v[15:0]};
      F3_BU:   return {24'd0, v[7:0]};
      F3_HU:   return {16'd0, v[15:0]};
      F3_W:    return v;
      default: return v;
    endcase
  endfunction

  function automatic logic access_err(input logic we, input logic [2:0] f3, input logic [1:0] a);
    logic bad;
    if (we) bad = f3[2] || (f3[1:0] == 2'b11);
    else    bad = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
`ifdef LSU_MISALIGN_TRAP_EN
    bad = bad || ((f3[1:0] == 2'b01) && a[0]) || ((f3[1:0] == 2'b10) && (a != 2'b00));
`else
    bad = bad || (a == 2'b11 && 1'b0);
`endif
    return bad;
  endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Core-side request/response bus of the load/store unit.
interface lsu_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/load_store_unit_lane_fmt.sv
// Combinational byte-lane logic: store merge into the old word, load extract and extend.
module lsu_lane_fmt
  import riscv_lsu_pkg::*;
(
  input  logic [2:0]  f3_i,
  input  logic [1:0]  off_i,
  input  logic [31:0] old_word_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rd_word_i,
  output logic [31:0] merged_o,
  output logic [31:0] load_o
);

  logic [3:0]  mask;
  logic [31:0] rep;
  logic [31:0] shifted;

  always_comb begin
    // NOTE: every output gets a default first so no path can infer a latch.
    merged_o = old_word_i;
    mask     = lane_mask(f3_i, off_i);
    case (f3_i[1:0])
      2'b00:   rep = {4{wdata_i[7:0]}};
      2'b01:   rep = {2{wdata_i[15:0]}};
      default: rep = wdata_i;
    endcase
    for (int i = 0; i < 4; i++) begin
      if (mask[i]) merged_o[8*i +: 8] = rep[8*i +: 8];
    end
    shifted = rd_word_i >> {lane_off(f3_i, off_i), 3'b000};
    load_o  = extend(shifted, f3_i);
  end

endmodule

// File: rtl/load_store_unit.sv
// RV32I load/store unit: sub-word loads with extension, sub-word stores via read-modify-write.
// Misalignment trapping is enabled by defining LSU_MISALIGN_TRAP_EN (see riscv_lsu_pkg).
module load_store_unit
  import riscv_lsu_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int MEM_WORDS = 64
) (
  input  logic        clk,
  input  logic        rst,
  lsu_if.slave        core,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  output logic        mem_we_o,
  input  logic [31:0] mem_rdata_i
);

  if (XLEN != LSU_XLEN || MEM_WORDS < 1) begin : g_cfg_err
    $error("load_store_unit supports only XLEN=32 and MEM_WORDS>=1");
  end

  lsu_state_e  state_q;
  logic [31:0] addr_q;
  logic [2:0]  f3_q;
  logic        we_q;
  logic [31:0] wdata_q;
  logic [31:0] word_q;
  logic        rsp_valid_q;
  logic [31:0] rsp_rdata_q;
  logic        rsp_err_q;
  logic        mem_we_q;

  logic        err_d;
  logic [31:0] load_d;
  logic [31:0] merged_d;

  assign err_d = access_err(we_q, f3_q, addr_q[1:0]);

  lsu_lane_fmt u_lane_fmt (
    .f3_i       (f3_q),
    .off_i      (addr_q[1:0]),
    .old_word_i (word_q),
    .wdata_i    (wdata_q),
    .rd_word_i  (mem_rdata_i),
    .merged_o   (merged_d),
    .load_o     (load_d)
  );

  // mem_we_q sits in the async-reset flop so a reset in WR kills the write at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      f3_q        <= '0;
      we_q        <= 1'b0;
      wdata_q     <= '0;
      word_q      <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      mem_we_q    <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all flops update together.
      rsp_valid_q <= 1'b0;
      mem_we_q    <= 1'b0;
      case (state_q)
        IDLE: begin
          if (core.req_valid) begin
            addr_q  <= core.req_addr;
            f3_q    <= core.req_funct3;
            we_q    <= core.req_we;
            wdata_q <= core.req_wdata;
            state_q <= RD;
          end
        end
        RD: begin
          word_q <= mem_rdata_i;
          if (err_d) begin
            rsp_err_q   <= 1'b1;
            rsp_rdata_q <= '0;
            rsp_valid_q <= 1'b1;
            state_q     <= RSP;
          end else if (we_q) begin
            mem_we_q <= 1'b1;
            state_q  <= WR;
          end else begin
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= load_d;
            rsp_valid_q <= 1'b1;
            state_q     <= RSP;
          end
        end
        WR: begin
          rsp_err_q   <= 1'b0;
          rsp_rdata_q <= '0;
          rsp_valid_q <= 1'b1;
          state_q     <= RSP;
        end
        RSP:     state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign core.req_ready = (state_q == IDLE);
  assign core.rsp_valid = rsp_valid_q;
  assign core.rsp_rdata = rsp_rdata_q;
  assign core.rsp_err   = rsp_err_q;
  assign mem_addr_o     = {addr_q[31:2], 2'b00};
  assign mem_wdata_o    = merged_d;
  assign mem_we_o       = mem_we_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a response scoreboard and a word memory model.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_we;
  logic [31:0] mem_rdata;

  lsu_if bus ();

  load_store_unit #(.XLEN(32), .MEM_WORDS(64)) dut (
    .clk         (clk),
    .rst         (rst),
    .core        (bus),
    .mem_addr_o  (mem_addr),
    .mem_wdata_o (mem_wdata),
    .mem_we_o    (mem_we),
    .mem_rdata_i (mem_rdata)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [64];
  logic        pre_en = 1'b0;
  logic [5:0]  pre_idx = '0;
  logic [31:0] pre_data = '0;

  assign mem_rdata = mem[mem_addr[7:2]];

  always @(posedge clk) begin
    if (pre_en)      mem[pre_idx] <= pre_data;
    else if (mem_we) mem[mem_addr[7:2]] <= mem_wdata;
  end

  typedef struct {
    string       tag;
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  always @(negedge clk) begin
    if (bus.rsp_valid === 1'b1) begin
      if (sb_q.size() == 0) begin
        check("rsp_unexpected", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check({"rdata:", e.tag}, bus.rsp_rdata, e.rdata);
        check({"err:", e.tag}, {31'd0, bus.rsp_err}, {31'd0, e.err});
      end
    end
  end

  task automatic preload(input logic [5:0] idx, input logic [31:0] data);
    @(negedge clk);
    pre_idx  = idx;
    pre_data = data;
    pre_en   = 1'b1;
    @(negedge clk);
    pre_en   = 1'b0;
  endtask

  // Caller is at a negedge with the DUT idle; returns at the negedge where req_ready is back.
  task automatic run(input string tag, input logic we, input logic [2:0] f3,
                     input logic [31:0] addr, input logic [31:0] wdata,
                     input logic [31:0] exp_rdata, input logic exp_err);
    int lat, we_cnt, busy, exp_lat;
    logic [31:0] rd_addr;
    exp_t e;
    lat = 0; we_cnt = 0; busy = 0; rd_addr = 'x;
    exp_lat = (we && !exp_err) ? 3 : 2;
    e.tag = tag; e.rdata = exp_rdata; e.err = exp_err;
    sb_q.push_back(e);
    bus.req_valid  = 1'b1;
    bus.req_we     = we;
    bus.req_funct3 = f3;
    bus.req_addr   = addr;
    bus.req_wdata  = wdata;
    check({"ready_at_issue:", tag}, {31'd0, bus.req_ready}, 32'd1);
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (k == 1) rd_addr = mem_addr;
      if (mem_we === 1'b1) we_cnt++;
      if (bus.rsp_valid === 1'b1 && lat == 0) lat = k;
      if (bus.req_ready === 1'b1) begin
        busy = k - 1;
        break;
      end
    end
    check({"latency:", tag}, lat, exp_lat);
    check({"busy:", tag}, busy, exp_lat);
    check({"we_pulses:", tag}, we_cnt, (we && !exp_err) ? 1 : 0);
    check({"mem_addr:", tag}, rd_addr, {addr[31:2], 2'b00});
  endtask

  initial begin
    bus.req_valid  = 1'b0;
    bus.req_we     = 1'b0;
    bus.req_funct3 = '0;
    bus.req_addr   = '0;
    bus.req_wdata  = '0;
    for (int i = 0; i < 64; i++) mem[i] = 32'h0;

    #12;
    check("rst_ready",     {31'd0, bus.req_ready}, 32'd1);
    check("rst_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
    check("rst_rdata",     bus.rsp_rdata, 32'd0);
    check("rst_err",       {31'd0, bus.rsp_err}, 32'd0);
    check("rst_mem_we",    {31'd0, mem_we}, 32'd0);
    check("rst_mem_addr",  mem_addr, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Byte loads with sign and zero extension
    preload(6'd4, 32'h8899AABB);
    run("lb_11",  1'b0, 3'b000, 32'h11, 32'h0, 32'hFFFFFFAA, 1'b0);
    check("rdata_held", bus.rsp_rdata, 32'hFFFFFFAA);
    run("lbu_11", 1'b0, 3'b100, 32'h11, 32'h0, 32'h000000AA, 1'b0);

    // Byte store: only lane 2 changes; upper wdata bits must be ignored
    run("sb_12", 1'b1, 3'b000, 32'h12, 32'hFFFFFF55, 32'h0, 1'b0);
    check("mem_after_sb", mem[4], 32'h8855AABB);

    // Half store and loads
    preload(6'd8, 32'hDEADBEEF);
    run("sh_22", 1'b1, 3'b001, 32'h22, 32'hABCD1234, 32'h0, 1'b0);
    check("mem_after_sh", mem[8], 32'h1234BEEF);
    run("lh_22",  1'b0, 3'b001, 32'h22, 32'h0, 32'h00001234, 1'b0);
    run("lh_20",  1'b0, 3'b001, 32'h20, 32'h0, 32'hFFFFBEEF, 1'b0);
    run("lhu_20", 1'b0, 3'b101, 32'h20, 32'h0, 32'h0000BEEF, 1'b0);

    // Back-to-back word store then load
    run("sw_3c", 1'b1, 3'b010, 32'h3C, 32'h13579BDF, 32'h0, 1'b0);
    run("lw_3c", 1'b0, 3'b010, 32'h3C, 32'h0, 32'h13579BDF, 1'b0);
    check("mem_after_sw", mem[15], 32'h13579BDF);

    // Illegal funct3 for a store and for a load
    run("st_f3_100", 1'b1, 3'b100, 32'h10, 32'h01020304, 32'h0, 1'b1);
    check("mem_after_bad_st", mem[4], 32'h8855AABB);
    run("ld_f3_011", 1'b0, 3'b011, 32'h10, 32'h0, 32'h0, 1'b1);
    run("st_f3_011", 1'b1, 3'b011, 32'h10, 32'hFFFFFFFF, 32'h0, 1'b1);
    check("mem_after_bad_st2", mem[4], 32'h8855AABB);

`ifdef LSU_MISALIGN_TRAP_EN
    run("lw_13_trap", 1'b0, 3'b010, 32'h13, 32'h0, 32'h0, 1'b1);
    run("lh_21_trap", 1'b0, 3'b001, 32'h21, 32'h0, 32'h0, 1'b1);
    run("sh_21_trap", 1'b1, 3'b001, 32'h21, 32'h00007777, 32'h0, 1'b1);
    check("mem_after_trap", mem[8], 32'h1234BEEF);
`else
    run("lw_13_noalign", 1'b0, 3'b010, 32'h13, 32'h0, 32'h8855AABB, 1'b0);
    run("lh_21_noalign", 1'b0, 3'b001, 32'h21, 32'h0, 32'hFFFFBEEF, 1'b0);
    run("sh_21_noalign", 1'b1, 3'b001, 32'h21, 32'h00007777, 32'h0, 1'b0);
    check("mem_after_sh21", mem[8], 32'h12347777);
`endif

    // Reset asserted while the store is in WR
    preload(6'd2, 32'h11223344);
    bus.req_valid  = 1'b1;
    bus.req_we     = 1'b1;
    bus.req_funct3 = 3'b010;
    bus.req_addr   = 32'h08;
    bus.req_wdata  = 32'hCAFEF00D;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    @(posedge clk);
    #2;
    check("wr_mem_we_high", {31'd0, mem_we}, 32'd1);
    rst = 1'b1;
    #1;
    check("rst_mid_mem_we", {31'd0, mem_we}, 32'd0);
    @(posedge clk);
    #1;
    check("rst_mid_ready",     {31'd0, bus.req_ready}, 32'd1);
    check("rst_mid_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
    check("rst_mid_rdata",     bus.rsp_rdata, 32'd0);
    check("rst_mid_err",       {31'd0, bus.rsp_err}, 32'd0);
    check("rst_mid_mem_addr",  mem_addr, 32'd0);
    check("mem_after_abort",   mem[2], 32'h11223344);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    run("lw_08_after_rst", 1'b0, 3'b010, 32'h08, 32'h0, 32'h11223344, 1'b0);

    repeat (3) @(negedge clk);
    check("sb_empty", sb_q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #100000;
    check("global_timeout", 32'd1, 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $fatal(1, "timeout");
  end

endmodule
